// File: rtl/gate_exerciser.sv
// gate_exerciser: drives every {a,b} combination into a two-input gate
// unit, waits a programmable settle time, then checks its seven outputs
// against locally computed expected values. The block reports pass/fail,
// a saturating error count, and a capture of the first mismatch.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; results of the last run are held
// SETTLE | a/b driven, settle timer counting down to terminal count
// CHECK  | one cycle: compare gate_out, log failure, advance vector
// DONE   | one cycle: done pulse, pass updated, a/b returned to 0

module gate_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [6:0]       gate_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_mask
);

  // Settle timer is a down-counter reloaded with SETTLE_CYCLES-1; SETTLE
  // ends when it reaches zero, so a/b are held for SETTLE_CYCLES cycles.
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LAST_LOOP   = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        vec;
  logic [SET_W-1:0]  settle_cnt;
  logic [LOOP_W-1:0] loop_cnt;
  logic [6:0]        expected;
  logic [6:0]        mismatch;
  logic              vec_fail;
  logic              last_vec;

  // a/b come straight from the vector register, so they are registered.
  assign a = vec[1];
  assign b = vec[0];

  // Expected gate response for the current vector and the failure decision.
  always_comb begin
    expected[0] = a & b;
    expected[1] = a | b;
    expected[2] = ~a;
    expected[3] = ~(a & b);
    expected[4] = ~(a | b);
    expected[5] = a ^ b;
    expected[6] = ~(a ^ b);
    mismatch    = expected ^ gate_out;
    vec_fail    = |mismatch;
    last_vec    = (vec == 2'b11) && (loop_cnt == LAST_LOOP);
  end

  // Sequencer: run control, stimulus stepping and result logging.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      vec             <= 2'b00;
      settle_cnt      <= '0;
      loop_cnt        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      fail_valid      <= 1'b0;
      first_fail_vec  <= 2'b00;
      first_fail_mask <= 7'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= SETTLE;
            vec             <= 2'b00;
            loop_cnt        <= '0;
            settle_cnt      <= SETTLE_LOAD;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= '0;
            fail_valid      <= 1'b0;
            first_fail_vec  <= 2'b00;
            first_fail_mask <= 7'b0;
          end
        end

        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end

        CHECK: begin
          // One failure per vector regardless of how many bits differ.
          if (vec_fail) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + ERR_W'(1);
            end
            if (!fail_valid) begin
              fail_valid      <= 1'b1;
              first_fail_vec  <= vec;
              first_fail_mask <= mismatch;
            end
          end
          if (last_vec) begin
            // fail_valid is sticky, so it stands in for err_count==0
            // including the failure being logged on this same edge.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ~(fail_valid | vec_fail);
            vec   <= 2'b00;
          end else begin
            state      <= SETTLE;
            vec        <= vec + 2'b01;
            settle_cnt <= SETTLE_LOAD;
            if (vec == 2'b11) begin
              loop_cnt <= loop_cnt + LOOP_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          vec   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Testbench for gate_exerciser: a behavioural gate model (optionally with
// the xor output stuck at 0) on the main instance, plus a second instance
// with a narrow error counter and its gate inputs tied low.

module tb_gate_exerciser;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       fault;
  logic       a, b;
  logic [6:0] gate_out;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic       fail_valid;
  logic [1:0] first_fail_vec;
  logic [6:0] first_fail_mask;

  logic       sat_start;
  logic       sat_a, sat_b;
  logic       sat_busy, sat_done, sat_pass;
  logic [1:0] sat_err_count;
  logic       sat_fail_valid;
  logic [1:0] sat_first_fail_vec;
  logic [6:0] sat_first_fail_mask;

  int checks = 0;
  int passed = 0;

  gate_exerciser #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .gate_out(gate_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_valid(fail_valid),
    .first_fail_vec(first_fail_vec), .first_fail_mask(first_fail_mask)
  );

  gate_exerciser #(.SETTLE_CYCLES(1), .LOOPS(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(sat_start), .a(sat_a), .b(sat_b),
    .gate_out(7'b0000000), .busy(sat_busy), .done(sat_done), .pass(sat_pass),
    .err_count(sat_err_count), .fail_valid(sat_fail_valid),
    .first_fail_vec(sat_first_fail_vec), .first_fail_mask(sat_first_fail_mask)
  );

  // Gate unit model: [0]and [1]or [2]not [3]nand [4]nor [5]xor [6]xnor
  always_comb begin
    gate_out = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    if (fault) gate_out[5] = 1'b0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Pulse start, then advance until the done cycle (bounded).
  task automatic do_run(output int busy_cycles, output int done_seen);
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cycles = 0;
    done_seen   = 0;
    for (int i = 0; i < 200 && done_seen == 0; i++) begin
      if (busy) busy_cycles++;
      if (done) done_seen = 1;
      else step();
    end
  endtask

  typedef struct {
    int         cyc;
    logic [1:0] vec;
    logic       busy;
    logic       done;
  } cyc_vec_t;

  typedef struct {
    logic       fault;
    logic       pass;
    logic [7:0] err;
    logic       fv;
    logic [1:0] ffv;
    logic [6:0] ffm;
  } run_vec_t;

  cyc_vec_t cyc_tbl[13];
  run_vec_t run_tbl[3];

  initial begin
    int bc, ds, dcount;

    // Test 1 per-cycle waveform: start sampled at edge 0, SETTLE=2.
    cyc_tbl[0]  = '{1,  2'b00, 1'b1, 1'b0};
    cyc_tbl[1]  = '{2,  2'b00, 1'b1, 1'b0};
    cyc_tbl[2]  = '{3,  2'b00, 1'b1, 1'b0};
    cyc_tbl[3]  = '{4,  2'b01, 1'b1, 1'b0};
    cyc_tbl[4]  = '{5,  2'b01, 1'b1, 1'b0};
    cyc_tbl[5]  = '{6,  2'b01, 1'b1, 1'b0};
    cyc_tbl[6]  = '{7,  2'b10, 1'b1, 1'b0};
    cyc_tbl[7]  = '{8,  2'b10, 1'b1, 1'b0};
    cyc_tbl[8]  = '{9,  2'b10, 1'b1, 1'b0};
    cyc_tbl[9]  = '{10, 2'b11, 1'b1, 1'b0};
    cyc_tbl[10] = '{11, 2'b11, 1'b1, 1'b0};
    cyc_tbl[11] = '{12, 2'b11, 1'b1, 1'b0};
    cyc_tbl[12] = '{13, 2'b00, 1'b0, 1'b1};

    // Run results at the done cycle: correct, xor stuck at 0, correct.
    run_tbl[0] = '{1'b0, 1'b1, 8'd0, 1'b0, 2'b00, 7'b0000000};
    run_tbl[1] = '{1'b1, 1'b0, 8'd2, 1'b1, 2'b01, 7'b0100000};
    run_tbl[2] = '{1'b0, 1'b1, 8'd0, 1'b0, 2'b00, 7'b0000000};

    rst_n = 1'b0; start = 1'b0; sat_start = 1'b0; fault = 1'b0;
    step(); step();
    check("reset_outputs", 32'({a, b, busy, done, pass, err_count, fail_valid,
                                first_fail_vec, first_fail_mask}), 32'd0);
    check("reset_sat_outputs", 32'({sat_a, sat_b, sat_busy, sat_done, sat_pass,
                                    sat_err_count, sat_fail_valid, sat_first_fail_vec,
                                    sat_first_fail_mask}), 32'd0);
    rst_n = 1'b1;
    step();

    // Test 1: cycle-accurate waveform of a clean run.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      check($sformatf("t1_ab_cyc%0d", cyc_tbl[i].cyc), 32'({a, b}), 32'(cyc_tbl[i].vec));
      check($sformatf("t1_busy_cyc%0d", cyc_tbl[i].cyc), 32'(busy), 32'(cyc_tbl[i].busy));
      check($sformatf("t1_done_cyc%0d", cyc_tbl[i].cyc), 32'(done), 32'(cyc_tbl[i].done));
      if (i == 12) begin
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_fv", 32'(fail_valid), 32'd0);
      end
      step();
    end
    check("t1_done_cleared", 32'(done), 32'd0);

    // Tests 2 and 6: table of back-to-back runs with/without the xor fault.
    for (int i = 0; i < 3; i++) begin
      fault = run_tbl[i].fault;
      do_run(bc, ds);
      check($sformatf("run%0d_done_seen", i), 32'(ds), 32'd1);
      check($sformatf("run%0d_busy_cycles", i), 32'(bc), 32'd12);
      check($sformatf("run%0d_pass", i), 32'(pass), 32'(run_tbl[i].pass));
      check($sformatf("run%0d_err", i), 32'(err_count), 32'(run_tbl[i].err));
      check($sformatf("run%0d_fv", i), 32'(fail_valid), 32'(run_tbl[i].fv));
      check($sformatf("run%0d_ffv", i), 32'(first_fail_vec), 32'(run_tbl[i].ffv));
      check($sformatf("run%0d_ffm", i), 32'(first_fail_mask), 32'(run_tbl[i].ffm));
      step();
    end
    fault = 1'b0;

    // Test 3: narrow counter saturates, first capture is vector 00.
    sat_start = 1'b1;
    step();
    sat_start = 1'b0;
    bc = 0; ds = 0;
    for (int i = 0; i < 200 && ds == 0; i++) begin
      if (sat_busy) bc++;
      if (sat_done) ds = 1;
      else step();
    end
    check("t3_done_seen", 32'(ds), 32'd1);
    check("t3_busy_cycles", 32'(bc), 32'd16);
    check("t3_err_sat", 32'(sat_err_count), 32'd3);
    check("t3_fv", 32'(sat_fail_valid), 32'd1);
    check("t3_ffv", 32'(sat_first_fail_vec), 32'd0);
    check("t3_ffm", 32'(sat_first_fail_mask), 32'(7'b1011100));
    check("t3_pass", 32'(sat_pass), 32'd0);
    check("t3_ab_zero", 32'({sat_a, sat_b}), 32'd0);
    step();

    // Test 4: start held high; first run faulty so clearing is visible.
    fault = 1'b1;
    start = 1'b1;
    step();
    dcount = 0;
    for (int i = 1; i <= 14; i++) begin
      if (done) dcount++;
      if (i == 13) begin
        check("t4_done_cyc13", 32'(done), 32'd1);
        check("t4_err_first_run", 32'(err_count), 32'd2);
      end
      if (i == 14) check("t4_idle_cyc14_busy", 32'(busy), 32'd0);
      step();
    end
    check("t4_single_done", 32'(dcount), 32'd1);
    check("t4_rerun_busy", 32'(busy), 32'd1);
    check("t4_rerun_cleared", 32'({pass, err_count, fail_valid, first_fail_vec,
                                   first_fail_mask}), 32'd0);
    fault = 1'b0;
    start = 1'b0;
    ds = 0;
    for (int i = 0; i < 200 && ds == 0; i++) begin
      if (done) ds = 1;
      else step();
    end
    check("t4_second_done", 32'(ds), 32'd1);
    check("t4_second_pass", 32'(pass), 32'd1);
    step();

    // Test 5: reset while vector 10 settles aborts with no done pulse.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t5_at_vec10", 32'({a, b}), 32'(2'b10));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_reset_outputs", 32'({a, b, busy, done, pass, err_count, fail_valid,
                                   first_fail_vec, first_fail_mask}), 32'd0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) dcount++;
      step();
    end
    check("t5_no_done_after_abort", 32'(dcount), 32'd0);
    do_run(bc, ds);
    check("t5_rerun_done", 32'(ds), 32'd1);
    check("t5_rerun_pass", 32'(pass), 32'd1);
    check("t5_rerun_err", 32'(err_count), 32'd0);
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
